// File: rtl/seq_pkg.sv
// seq_pkg: shared encodings for the stage sequencer.
// Holds the FSM state encoding, the err_code values reported on the
// err_code port and the width of the completed-sequence counter.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ACK   = 2'd2,
        ST_ERROR = 2'd3
    } seq_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_STAGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam int SEQ_CNT_W = 16;

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: per-stage timeout counter for the stage sequencer.
// The count restarts on clear, advances on every enabled cycle and
// saturates at TIMEOUT-1; expired is a registered flag raised on the edge
// where the count reaches TIMEOUT-1, so the sequencer reacts on the edge
// after that.
module seq_watchdog #(
    parameter int                   TIMEOUT_W = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT - TIMEOUT_W'(1'b1);

    logic [TIMEOUT_W-1:0] count_r;
    logic [TIMEOUT_W-1:0] count_s;

    // Next count: clear wins, otherwise advance while enabled until the limit.
    always_comb begin
        count_s = count_r;
        if (clear) begin
            count_s = {TIMEOUT_W{1'b0}};
        end else if (enable && (count_r != LIMIT)) begin
            count_s = count_r + TIMEOUT_W'(1'b1);
        end else begin
            count_s = count_r;
        end
    end

    // Count register and registered expiry flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {TIMEOUT_W{1'b0}};
            expired <= 1'b0;
        end else begin
            count_r <= count_s;
            expired <= !clear && (count_s == LIMIT);
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: drives N_STAGES processing stages one at a time, in index
// order, through a start/done/ack handshake. Supports one-shot (single) and
// continuous (run) modes, captures the faulting stage and cause, and counts
// completed sequences.
// Optional feature macro: SEQ_TIMEOUT_EN builds the per-stage watchdog
// (seq_watchdog) so err_code can report a timeout; without it a stage may
// hold RUN/ACK indefinitely and TIMEOUT/TIMEOUT_W have no effect.
// All outputs are Moore outputs registered from the internal state, so each
// output follows the decision edge by one clock.
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int                   N_STAGES  = 2,
    parameter int                   IDX_W     = 3,
    parameter int                   TIMEOUT_W = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd5_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 single,
    input  logic                 clear_err,
    input  logic [N_STAGES-1:0]  stage_done,
    input  logic [N_STAGES-1:0]  stage_error,
    output logic [N_STAGES-1:0]  stage_start,
    output logic [N_STAGES-1:0]  stage_ack,
    output logic                 busy,
    output logic [IDX_W-1:0]     cur_stage,
    output logic                 seq_error,
    output logic [IDX_W-1:0]     err_stage,
    output logic [1:0]           err_code,
    output logic [SEQ_CNT_W-1:0] seq_count
);

    // Internal state (decision registers).
    seq_state_e           state_r;
    seq_state_e           state_s;
    logic [IDX_W-1:0]     cur_r;
    logic [IDX_W-1:0]     cur_s;
    logic                 single_only_r;
    logic                 single_only_s;
    logic [IDX_W-1:0]     err_stage_r;
    logic [IDX_W-1:0]     err_stage_s;
    logic [1:0]           err_code_r;
    logic [1:0]           err_code_s;
    logic [SEQ_CNT_W-1:0] seq_cnt_r;
    logic [SEQ_CNT_W-1:0] seq_cnt_s;

    // Decoded view of the active stage.
    logic                 sel_done_s;
    logic                 sel_error_s;
    logic [N_STAGES-1:0]  cur_onehot_s;
    logic                 last_stage_s;
    logic                 expired_s;

    // Select the active stage's done/error and build its one-hot mask;
    // inputs of all other stages are ignored here.
    always_comb begin
        sel_done_s   = 1'b0;
        sel_error_s  = 1'b0;
        cur_onehot_s = {N_STAGES{1'b0}};
        for (int i = 0; i < N_STAGES; i++) begin
            cur_onehot_s[i] = (cur_r == IDX_W'(i));
            sel_done_s      = sel_done_s  | (cur_onehot_s[i] & stage_done[i]);
            sel_error_s     = sel_error_s | (cur_onehot_s[i] & stage_error[i]);
        end
        last_stage_s = (cur_r == IDX_W'(N_STAGES - 1));
    end

`ifdef SEQ_TIMEOUT_EN
    logic wd_clear_s;
    logic wd_enable_s;

    // Watchdog restarts on every entry into RUN and counts through RUN/ACK.
    always_comb begin
        wd_clear_s  = (state_s == ST_RUN) && (state_r != ST_RUN);
        wd_enable_s = (state_r == ST_RUN) || (state_r == ST_ACK);
    end

    seq_watchdog #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (expired_s)
    );
`else
    logic unused_timeout_cfg_s;

    assign expired_s            = 1'b0;
    assign unused_timeout_cfg_s = ^TIMEOUT;
`endif

    // Next-state logic: stage error beats timeout, timeout beats done.
    always_comb begin
        state_s       = state_r;
        cur_s         = cur_r;
        single_only_s = single_only_r;
        err_stage_s   = err_stage_r;
        err_code_s    = err_code_r;
        seq_cnt_s     = seq_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (run || single) begin
                    state_s       = ST_RUN;
                    cur_s         = {IDX_W{1'b0}};
                    single_only_s = !run;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sel_error_s) begin
                    state_s     = ST_ERROR;
                    err_stage_s = cur_r;
                    err_code_s  = ERR_STAGE;
                end else if (expired_s) begin
                    state_s     = ST_ERROR;
                    err_stage_s = cur_r;
                    err_code_s  = ERR_TIMEOUT;
                end else if (sel_done_s) begin
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ACK: begin
                if (sel_error_s) begin
                    state_s     = ST_ERROR;
                    err_stage_s = cur_r;
                    err_code_s  = ERR_STAGE;
                end else if (expired_s) begin
                    state_s     = ST_ERROR;
                    err_stage_s = cur_r;
                    err_code_s  = ERR_TIMEOUT;
                end else if (sel_done_s) begin
                    state_s = ST_ACK;
                end else if (!last_stage_s) begin
                    state_s = ST_RUN;
                    cur_s   = cur_r + IDX_W'(1'b1);
                end else begin
                    // Sequence complete; a run drop never aborts, it only
                    // prevents the next sequence from starting.
                    seq_cnt_s = seq_cnt_r + 16'd1;
                    cur_s     = {IDX_W{1'b0}};
                    if (run && !single_only_r) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            ST_ERROR: begin
                if (clear_err) begin
                    state_s    = ST_IDLE;
                    cur_s      = {IDX_W{1'b0}};
                    err_code_s = ERR_NONE;
                end else begin
                    state_s = ST_ERROR;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                cur_s      = {IDX_W{1'b0}};
                err_code_s = ERR_NONE;
            end
        endcase
    end

    // Decision registers; the counter is rewritten every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            cur_r         <= {IDX_W{1'b0}};
            single_only_r <= 1'b0;
            err_stage_r   <= {IDX_W{1'b0}};
            err_code_r    <= ERR_NONE;
            seq_cnt_r     <= {SEQ_CNT_W{1'b0}};
        end else begin
            state_r       <= state_s;
            cur_r         <= cur_s;
            single_only_r <= single_only_s;
            err_stage_r   <= err_stage_s;
            err_code_r    <= err_code_s;
            seq_cnt_r     <= seq_cnt_s;
        end
    end

    // Registered Moore outputs decoded from the decision registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_start <= {N_STAGES{1'b0}};
            stage_ack   <= {N_STAGES{1'b0}};
            busy        <= 1'b0;
            cur_stage   <= {IDX_W{1'b0}};
            seq_error   <= 1'b0;
            err_stage   <= {IDX_W{1'b0}};
            err_code    <= ERR_NONE;
            seq_count   <= {SEQ_CNT_W{1'b0}};
        end else begin
            stage_start <= (state_r == ST_RUN) ? cur_onehot_s : {N_STAGES{1'b0}};
            stage_ack   <= (state_r == ST_ACK) ? cur_onehot_s : {N_STAGES{1'b0}};
            busy        <= (state_r == ST_RUN) || (state_r == ST_ACK);
            cur_stage   <= cur_r;
            seq_error   <= (state_r == ST_ERROR);
            err_stage   <= err_stage_r;
            err_code    <= err_code_r;
            seq_count   <= seq_cnt_r;
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed, table-driven bench for stage_sequencer with
// three stages. A table walks a manual handshake cycle by cycle; hand-written
// sequences cover auto-responding slaves, continuous mode, async reset,
// counter wrap and (with SEQ_TIMEOUT_EN) the watchdog.
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        single;
    logic        clear_err;
    logic [2:0]  stage_done;
    logic [2:0]  stage_error;
    logic [2:0]  stage_start;
    logic [2:0]  stage_ack;
    logic        busy;
    logic [1:0]  cur_stage;
    logic        seq_error;
    logic [1:0]  err_stage;
    logic [1:0]  err_code;
    logic [15:0] seq_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Slave model state.
    logic [2:0] auto_en;
    int         st_cnt [3];
    int         ak_cnt [3];
    logic [2:0] prev_start;
    logic [2:0] prev_ack;
    int         ev_q [$];

    typedef struct {
        logic        run;
        logic        single;
        logic        clr;
        logic [2:0]  done;
        logic [2:0]  err;
        logic [2:0]  e_start;
        logic [2:0]  e_ack;
        logic        e_busy;
        logic [1:0]  e_cur;
        logic        e_serr;
        logic [1:0]  e_estage;
        logic [1:0]  e_ecode;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [19];

    stage_sequencer #(
        .N_STAGES  (3),
        .IDX_W     (2),
        .TIMEOUT_W (8),
        .TIMEOUT   (8'd16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .single      (single),
        .clear_err   (clear_err),
        .stage_done  (stage_done),
        .stage_error (stage_error),
        .stage_start (stage_start),
        .stage_ack   (stage_ack),
        .busy        (busy),
        .cur_stage   (cur_stage),
        .seq_error   (seq_error),
        .err_stage   (err_stage),
        .err_code    (err_code),
        .seq_count   (seq_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_slaves();
        stage_done = 3'b000;
        for (int i = 0; i < 3; i++) begin
            st_cnt[i] = 0;
            ak_cnt[i] = 0;
        end
    endtask

    // One clock: sample after the edge, log start/ack rises, run auto slaves
    // (done 3 cycles after start, dropped 2 cycles after ack).
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (stage_start[i] && !prev_start[i]) ev_q.push_back(i);
            if (stage_ack[i] && !prev_ack[i]) ev_q.push_back(10 + i);
            if (auto_en[i]) begin
                if (stage_start[i]) begin
                    st_cnt[i]++;
                    if (st_cnt[i] == 3) stage_done[i] = 1'b1;
                end else begin
                    st_cnt[i] = 0;
                end
                if (stage_ack[i]) begin
                    ak_cnt[i]++;
                    if (ak_cnt[i] == 2) stage_done[i] = 1'b0;
                end else begin
                    ak_cnt[i] = 0;
                end
            end
        end
        prev_start = stage_start;
        prev_ack   = stage_ack;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".start"}, stage_start, 3'b000);
        check({tag, ".ack"}, stage_ack, 3'b000);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".cur"}, cur_stage, 2'd0);
        check({tag, ".serr"}, seq_error, 1'b0);
        check({tag, ".estage"}, err_stage, 2'd0);
        check({tag, ".ecode"}, err_code, 2'd0);
        check({tag, ".cnt"}, seq_count, 16'd0);
    endtask

    initial begin
        int exp_ev [6];
        int t0;

        reset = 1'b0; run = 1'b0; single = 1'b0; clear_err = 1'b0;
        stage_error = 3'b000; auto_en = 3'b000;
        prev_start = 3'b000; prev_ack = 3'b000;
        clear_slaves();

        // Reset state.
        step(); step(); step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // Manual handshake table: row k outputs reflect the state decided at
        // edge k-1. Stage 1 raises error+done together; later a full
        // sequence with foreign done/error bits that must be ignored.
        //            run  sgl  clr  done    err     start   ack    busy  cur   serr  estg  ecode cnt
        tbl[0]  = '{1'b0,1'b1,1'b0,3'b000,3'b000, 3'b000,3'b000,1'b0,2'd0,1'b0,2'd0,2'd0,16'd0};
        tbl[1]  = '{1'b0,1'b0,1'b0,3'b000,3'b000, 3'b001,3'b000,1'b1,2'd0,1'b0,2'd0,2'd0,16'd0};
        tbl[2]  = '{1'b0,1'b0,1'b0,3'b001,3'b000, 3'b001,3'b000,1'b1,2'd0,1'b0,2'd0,2'd0,16'd0};
        tbl[3]  = '{1'b0,1'b0,1'b0,3'b001,3'b000, 3'b000,3'b001,1'b1,2'd0,1'b0,2'd0,2'd0,16'd0};
        tbl[4]  = '{1'b0,1'b0,1'b0,3'b000,3'b000, 3'b000,3'b001,1'b1,2'd0,1'b0,2'd0,2'd0,16'd0};
        tbl[5]  = '{1'b0,1'b0,1'b0,3'b000,3'b000, 3'b010,3'b000,1'b1,2'd1,1'b0,2'd0,2'd0,16'd0};
        tbl[6]  = '{1'b0,1'b0,1'b0,3'b010,3'b010, 3'b010,3'b000,1'b1,2'd1,1'b0,2'd0,2'd0,16'd0};
        tbl[7]  = '{1'b0,1'b0,1'b0,3'b000,3'b000, 3'b000,3'b000,1'b0,2'd1,1'b1,2'd1,2'd1,16'd0};
        tbl[8]  = '{1'b0,1'b0,1'b1,3'b000,3'b000, 3'b000,3'b000,1'b0,2'd1,1'b1,2'd1,2'd1,16'd0};
        tbl[9]  = '{1'b0,1'b0,1'b0,3'b000,3'b000, 3'b000,3'b000,1'b0,2'd0,1'b0,2'd1,2'd0,16'd0};
        tbl[10] = '{1'b0,1'b1,1'b1,3'b000,3'b000, 3'b000,3'b000,1'b0,2'd0,1'b0,2'd1,2'd0,16'd0};
        tbl[11] = '{1'b0,1'b1,1'b0,3'b110,3'b000, 3'b001,3'b000,1'b1,2'd0,1'b0,2'd1,2'd0,16'd0};
        tbl[12] = '{1'b0,1'b0,1'b0,3'b001,3'b000, 3'b001,3'b000,1'b1,2'd0,1'b0,2'd1,2'd0,16'd0};
        tbl[13] = '{1'b0,1'b0,1'b0,3'b000,3'b000, 3'b000,3'b001,1'b1,2'd0,1'b0,2'd1,2'd0,16'd0};
        tbl[14] = '{1'b0,1'b0,1'b0,3'b010,3'b000, 3'b010,3'b000,1'b1,2'd1,1'b0,2'd1,2'd0,16'd0};
        tbl[15] = '{1'b0,1'b0,1'b0,3'b000,3'b000, 3'b000,3'b010,1'b1,2'd1,1'b0,2'd1,2'd0,16'd0};
        tbl[16] = '{1'b0,1'b0,1'b0,3'b100,3'b001, 3'b100,3'b000,1'b1,2'd2,1'b0,2'd1,2'd0,16'd0};
        tbl[17] = '{1'b0,1'b0,1'b0,3'b000,3'b000, 3'b000,3'b100,1'b1,2'd2,1'b0,2'd1,2'd0,16'd0};
        tbl[18] = '{1'b0,1'b0,1'b0,3'b000,3'b000, 3'b000,3'b000,1'b0,2'd0,1'b0,2'd1,2'd0,16'd1};

        for (int r = 0; r < 19; r++) begin
            run = tbl[r].run; single = tbl[r].single; clear_err = tbl[r].clr;
            stage_done = tbl[r].done; stage_error = tbl[r].err;
            step();
            check($sformatf("row%0d.start", r), stage_start, tbl[r].e_start);
            check($sformatf("row%0d.ack", r), stage_ack, tbl[r].e_ack);
            check($sformatf("row%0d.busy", r), busy, tbl[r].e_busy);
            check($sformatf("row%0d.cur", r), cur_stage, tbl[r].e_cur);
            check($sformatf("row%0d.serr", r), seq_error, tbl[r].e_serr);
            check($sformatf("row%0d.estage", r), err_stage, tbl[r].e_estage);
            check($sformatf("row%0d.ecode", r), err_code, tbl[r].e_ecode);
            check($sformatf("row%0d.cnt", r), seq_count, tbl[r].e_cnt);
        end
        run = 1'b0; single = 1'b0; clear_err = 1'b0;
        stage_done = 3'b000; stage_error = 3'b000;

        // Single pulse with auto slaves: strict start/ack ordering.
        auto_en = 3'b111;
        ev_q.delete();
        single = 1'b1; step(); single = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (seq_count == 16'd2) break;
            step();
        end
        step();
        check("single.cnt", seq_count, 16'd2);
        check("single.busy", busy, 1'b0);
        exp_ev = '{0, 10, 1, 11, 2, 12};
        check("single.nev", ev_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("single.ev%0d", k), (k < ev_q.size()) ? ev_q[k] : -1, exp_ev[k]);
        end

        // Async reset while in ACK(1).
        single = 1'b1; step(); single = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (stage_ack[1]) break;
            step();
        end
        check("rst.reached_ack1", stage_ack, 3'b010);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst.async");
        clear_slaves();
        step(); step();
        reset = 1'b1;
        step();

        // Continuous mode: drop run during sequence 5, it must still finish.
        ev_q.delete();
        run = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (seq_count == 16'd4) break;
            step();
        end
        check("cont.cnt4", seq_count, 16'd4);
        run = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            step();
        end
        step(); step(); step();
        check("cont.cnt5", seq_count, 16'd5);
        check("cont.busy", busy, 1'b0);
        check("cont.nev", ev_q.size(), 30);
        check("cont.first", (ev_q.size() > 0) ? ev_q[0] : -1, 0);
        check("cont.last", (ev_q.size() > 0) ? ev_q[ev_q.size() - 1] : -1, 12);

`ifdef SEQ_TIMEOUT_EN
        // Watchdog: stage 0 never answers.
        auto_en = 3'b110;
        single = 1'b1; step(); single = 1'b0;
        t0 = -1000;
        for (int k = 0; k < 20; k++) begin
            if (stage_start[0]) break;
            step();
        end
        t0 = cyc;
        for (int k = 0; k < 60; k++) begin
            if (err_code != 2'd0) break;
            step();
        end
        check("wd.delay", cyc - t0, 16);
        check("wd.ecode", err_code, 2'd2);
        check("wd.estage", err_stage, 2'd0);
        check("wd.serr", seq_error, 1'b1);
        check("wd.start", stage_start, 3'b000);
        clear_err = 1'b1; step(); clear_err = 1'b0;
        step();
        check("wd.clr_ecode", err_code, 2'd0);
        check("wd.clr_busy", busy, 1'b0);
        auto_en = 3'b111;
        clear_slaves();
`else
        t0 = 0;
`endif

        // Counter wrap 0xFFFF -> 0x0000.
        force dut.seq_cnt_r = 16'hFFFF;
        step(); step();
        release dut.seq_cnt_r;
        step();
        check("wrap.pre", seq_count, 16'hFFFF);
        single = 1'b1; step(); single = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (seq_count == 16'h0000) break;
            step();
        end
        step(); step();
        check("wrap.cnt", seq_count, 16'h0000);
        check("wrap.busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised top-level task sequencer that drives N processing stages (camera capture, min/max filter, later stages) through a fixed start/done/ack handshake, one stage at a time, in index order. It replaces the hand-written two-stage FSM in the Nexys4 DDR top level. It adds:
- generic stage count
- per-stage error capture
- a watchdog timeout
- one-shot and continuous run modes
- a completed-sequence counter readable by the MIPS side.

## Interface
Parameters:
- N_STAGES, 2, number of sequenced stages (1..8)
- IDX_W, 3, width of stage index outputs (≥ clog2(N_STAGES), min 1)
- TIMEOUT_W, 24, watchdog counter width
- TIMEOUT, 24'd5_000_000, cycles allowed per stage (RUN+ACK combined) before timeout

Ports:
- clk  in  1  sequencer clock (clk_out_25MHZ domain); single clock domain
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; continuous mode while high
- single  in  1  one-cycle pulse; run exactly one sequence from IDLE
- clear_err  in  1  one-cycle pulse; leave ERROR
- stage_done  in  N_STAGES  per-stage done
- stage_error  in  N_STAGES  per-stage error
- stage_start  out  N_STAGES  per-stage start, one-hot or zero
- stage_ack  out  N_STAGES  per-stage ack, one-hot or zero
- busy  out  1  high in any state except IDLE/ERROR
- cur_stage  out  IDX_W  index of active stage
- seq_error  out  1  high in ERROR
- err_stage  out  IDX_W  stage index that faulted
- err_code  out  2  0 none, 1 stage_error, 2 timeout
- seq_count  out  16  completed sequences, wraps

## Operation
- All outputs are registered (Moore). On reset, every output is 0 and the state is IDLE.
- States: IDLE, RUN, ACK, ERROR.
- IDLE:
  - run=1 or single=1 → RUN with cur_stage=0.
  - A latched mode flag records single-only (run=0 at entry).
- RUN(i):
  - stage_start[i]=1; all other start/ack bits are 0.
  - stage_error[i]=1 → ERROR with err_code=1. This takes priority over a simultaneous stage_done[i].
  - Otherwise stage_done[i]=1 → ACK(i).
- ACK(i):
  - stage_ack[i]=1, start low.
  - Stay until stage_done[i]=0.
  - Then, if i<N_STAGES-1 → RUN(i+1).
  - Otherwise seq_count+1, then:
    - run=1 and not single-only → RUN(0);
    - else → IDLE.
  - stage_error[i] in ACK → ERROR, code 1.
- ERROR:
  - All start/ack are 0; seq_error=1.
  - err_stage and err_code hold until clear_err.
  - clear_err → IDLE and err_code=0. err_stage keeps its last value.
- Inputs of non-active stages are ignored.
- run falling mid-sequence: the current sequence completes, then IDLE. Deassertion is never an abort.
- single while busy: ignored. clear_err outside ERROR: ignored.
- seq_count wraps 0xFFFF→0x0000.

## Timing
- Output latency is one clock from the decision edge:
  - single sampled at edge k → stage_start[0]=1 after edge k+1.
  - stage_done sampled at edge k → start low / ack high after edge k+1.
- Stage-to-stage gap is one cycle: ack falls and the next start rises on the same edge.
- A sequence of N stages with zero-delay slaves takes 2N+ (done-drop latency) cycles.
- Watchdog:
  - Resets on entry to each RUN.
  - Counts every cycle in RUN/ACK.
  - Reaching TIMEOUT-1 → ERROR with err_code=2 on the next edge.
- Reset asserted mid-operation clears all outputs asynchronously. No stage receives ack; slaves must tolerate a dropped start.

## Configuration
- SEQ_TIMEOUT_EN defined: the watchdog is built and err_code=2 is reachable.
- Not defined:
  - No counter logic.
  - A stage may hold RUN/ACK indefinitely.
  - err_code only takes values 0/1.
  - TIMEOUT and TIMEOUT_W are unused.

## Structure
- Package seq_pkg: state encoding constants, err_code constants (ERR_NONE, ERR_STAGE, ERR_TIMEOUT), seq_count width.
- One sub-module, seq_watchdog:
  - Ports: clk, reset, clear, enable, expired.
  - Parametrised by TIMEOUT_W/TIMEOUT.
  - Instantiated only under SEQ_TIMEOUT_EN.

## Test plan
- N_STAGES=2, single pulse, each slave raises done 3 cycles after start and drops it 2 cycles after ack:
  - start0 → ack0 → start1 → ack1 occur in order;
  - seq_count=1, then IDLE, busy=0.
- N_STAGES=3, run held high for 4 sequences, then low mid-sequence 5:
  - seq_count=5;
  - the final sequence completes before IDLE.
- Stage 1 asserts error and done on the same cycle:
  - ERROR with err_stage=1, err_code=1, all start/ack=0;
  - clear_err → IDLE.
- SEQ_TIMEOUT_EN with TIMEOUT=16, stage 0 never raises done:
  - err_code=2 and err_stage=0 exactly 16 cycles after start0 rose.
- Reset pulsed while in ACK(1):
  - all outputs 0 asynchronously;
  - seq_count=0;
  - run=1 afterwards restarts at stage 0.
- Force seq_count to 0xFFFF, complete one sequence → seq_count=0x0000.
